// File: rtl/sequence_encode.sv
// rtl/sequence_encode.sv - ISO 14443-2 Type A PICC bit transmitter (Manchester D/E/F sequences, fc/16 subcarrier)
module sequence_encode #(
   parameter int BIT_TICKS       = 128,
   parameter int SUBCARRIER_HALF = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_data_valid,
   input  logic in_data,
   output logic in_req,
   output logic lm_out,
   output logic busy,
   output logic tx_done
);

   localparam int CW = $clog2(BIT_TICKS);
   localparam int SB = $clog2(SUBCARRIER_HALF);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SOC,
      S_DATA,
      S_EOC
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          bit_q, bit_d;
   logic          lm_q, lm_d;
   logic          req_q, req_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          last_tick;
   logic          first_half;
   logic          modulated;

   assign last_tick = (cnt_q == CW'(BIT_TICKS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= 1'b0;
         lm_q    <= 1'b0;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         lm_q    <= lm_d;
         req_q   <= req_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // The tick counter wraps naturally at each bit boundary, so EOC exits with cnt already 0.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      bit_d   = bit_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (in_data_valid) state_d = S_SOC;
         end
         S_SOC, S_DATA: begin
            if (last_tick) begin
               if (in_data_valid) begin
                  bit_d   = in_data;
                  state_d = S_DATA;
               end else begin
                  state_d = S_EOC;
               end
            end
         end
         S_EOC: begin
            if (last_tick) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from next-state values so the registered lm_out lines up with cnt.
   always_comb begin
      first_half = ~cnt_d[CW-1];
      modulated  = 1'b0;
      case (state_d)
         S_SOC:   modulated = first_half;
         S_DATA:  modulated = bit_d ? first_half : ~first_half;
         default: modulated = 1'b0;
      endcase
      lm_d   = modulated & ~cnt_d[SB];
      busy_d = (state_d != S_IDLE);
      req_d  = ((state_q == S_SOC) || (state_q == S_DATA)) && last_tick && in_data_valid;
      done_d = (state_q == S_EOC) && last_tick;
   end

   assign lm_out  = lm_q;
   assign in_req  = req_q;
   assign busy    = busy_q;
   assign tx_done = done_q;

endmodule

// File: tb/tb_sequence_encode.sv
// tb/tb_sequence_encode.sv - scoreboard bench for sequence_encode
module tb_sequence_encode;

   logic clk;
   logic rst_n;
   logic in_data_valid;
   logic in_data;
   logic in_req;
   logic lm_out;
   logic busy;
   logic tx_done;

   sequence_encode #(.BIT_TICKS(128), .SUBCARRIER_HALF(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_data_valid (in_data_valid),
      .in_data       (in_data),
      .in_req        (in_req),
      .lm_out        (lm_out),
      .busy          (busy),
      .tx_done       (tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int t_cur = 0;
   int req_cnt = 0;
   int busy_cnt = 0;
   int done_cnt = 0;
   int exp_q[$];
   logic [127:0] win;
   int pos = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc + 1);
      end
   endtask

   // 0 = D, 1 = E, 2 = F, 3 = malformed
   function automatic int classify(input logic [127:0] w);
      logic [127:0] pd;
      logic [127:0] pe;
      logic m;
      for (int i = 0; i < 128; i++) begin
         m = ((i / 8) % 2 == 0);
         pd[i] = (i < 64) ? m : 1'b0;
         pe[i] = (i >= 64) ? m : 1'b0;
      end
      if (w == pd) return 0;
      if (w == pe) return 1;
      if (w == '0) return 2;
      return 3;
   endfunction

   // Monitor: cut the busy window into 128-tick sequences and score them.
   always @(negedge clk) begin
      if (busy) begin
         win[pos] = lm_out;
         pos++;
         busy_cnt++;
         if (pos == 128) begin
            if (exp_q.size() == 0) check_eq("seq_unexpected", classify(win), -1);
            else check_eq("seq", classify(win), exp_q.pop_front());
            pos = 0;
         end
      end else begin
         pos = 0;
         if (lm_out) check_eq("lm_idle", lm_out, 0);
      end
      if (in_req) begin
         req_cnt++;
         check_eq("req_phase", (cyc + 1 - t_cur) % 128, 1);
      end
      if (tx_done) done_cnt++;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic start_frame(input int n, input logic [63:0] bits);
      exp_q.push_back(0);
      for (int i = 0; i < n; i++) exp_q.push_back(bits[i] ? 0 : 1);
      exp_q.push_back(2);
      t_cur = cyc + 1;
      in_data_valid = 1'b1;
      in_data = 1'($urandom);
   endtask

   // Drive the value the DUT sees at the edge ending cycle t_cur+k.
   task automatic drive(input int k, input int n, input logic [63:0] bits, input bit rnd, input bit hold);
      int m;
      if (k % 128 == 0) begin
         m = k / 128;
         if (m <= n) begin
            in_data_valid = 1'b1;
            in_data = bits[m-1];
         end else if (m == n + 1) begin
            in_data_valid = 1'b0;
            in_data = 1'($urandom);
         end else begin
            in_data_valid = hold;
            in_data = 1'b0;
         end
      end else if (rnd) begin
         in_data_valid = 1'($urandom);
         in_data = 1'($urandom);
      end else begin
         m = k / 128 + 1;
         in_data_valid = (m <= n) ? 1'b1 : ((m > n + 1) ? hold : 1'b0);
         in_data = (m <= n) ? bits[m-1] : 1'b0;
      end
   endtask

   task automatic run_frame(input int n, input logic [63:0] bits, input bit rnd, input bit hold);
      int t;
      int rq0;
      int bz0;
      int dn0;
      rq0 = req_cnt;
      bz0 = busy_cnt;
      dn0 = done_cnt;
      start_frame(n, bits);
      t = t_cur;
      for (int c = t + 1; c <= t + 128 * (n + 2); c++) begin
         tick();
         if (c == t + 1) check_eq("soc_start", {busy, lm_out}, 3);
         drive(c - t, n, bits, rnd, hold);
      end
      tick();
      check_eq("tx_done", tx_done, 1);
      check_eq("busy_at_done", busy, 0);
      check_eq("req_count", req_cnt - rq0, n);
      check_eq("busy_cycles", busy_cnt - bz0, 128 * (n + 2));
      check_eq("done_count", done_cnt - dn0, 1);
      if (!hold) in_data_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] rbits;
      int t;
      rst_n = 1'b0;
      in_data_valid = 1'b0;
      in_data = 1'b0;
      repeat (3) tick();
      check_eq("rst_lm", lm_out, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_req", in_req, 0);
      check_eq("rst_done", tx_done, 0);
      rst_n = 1'b1;
      repeat (3) tick();

      run_frame(8, 64'hA5, 1'b0, 1'b0);
      repeat (4) tick();

      run_frame(0, 64'h0, 1'b0, 1'b0);
      repeat (4) tick();

      rbits = {$urandom, $urandom};
      run_frame(10, rbits, 1'b1, 1'b0);
      repeat (4) tick();

      run_frame(1, 64'h1, 1'b0, 1'b1);
      run_frame(1, 64'h0, 1'b0, 1'b0);
      repeat (4) tick();

      // Reset during the first modulated tick of bit 3 (a D bit).
      start_frame(6, 64'h0B);
      t = t_cur;
      for (int c = t + 1; c <= t + 513; c++) begin
         tick();
         drive(c - t, 6, 64'h0B, 1'b0, 1'b0);
      end
      check_eq("pre_rst_lm", lm_out, 1);
      check_eq("pre_rst_req", in_req, 1);
      check_eq("pre_rst_busy", busy, 1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("async_rst_lm", lm_out, 0);
      check_eq("async_rst_busy", busy, 0);
      check_eq("async_rst_req", in_req, 0);
      check_eq("async_rst_done", tx_done, 0);
      exp_q.delete();
      in_data_valid = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      check_eq("post_rst_busy", busy, 0);
      check_eq("post_rst_lm", lm_out, 0);
      run_frame(2, 64'h2, 1'b0, 1'b0);
      repeat (4) tick();

      check_eq("sb_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sequence_encode.md
# sequence_encode

PICC → PCD bit transmitter for ISO/IEC 14443-2 Type A at 106 kbit/s. It pulls a serial bit stream from the framing logic and emits a Manchester-coded frame: SOC (sequence D), one sequence D/E per data bit, then EOC (sequence F). While a sequence requires modulation, it outputs the fc/16 (847.5 kHz) subcarrier on `lm_out`, which drives the analogue load modulator. It is the transmit-side counterpart of the PCD → PICC sequence decoder and runs on the same recovered 13.56 MHz clock, which runs continuously during PICC transmission.

## Interface
- `BIT_TICKS`, 128: clock ticks per bit time. Fixed by standard; the block requires a power of two.
- `SUBCARRIER_HALF`, 8: ticks per subcarrier half-period. Fixed by standard; the block requires a power of two that divides `BIT_TICKS/2`.
- `clk`  in  1  13.56 MHz recovered carrier clock.
- `rst_n`  in  1  Reset, asynchronous, active-low.
- `in_data_valid`  in  1  Source has a bit available.
  - Sampled high in IDLE: starts a frame.
  - Sampled low at end of bit: ends the frame.
- `in_data`  in  1  Next data bit. 1 → sequence D, 0 → sequence E.
- `in_req`  out  1  One-tick pulse: the bit on `in_data` was consumed, so the source advances.
- `lm_out`  out  1  Load-modulation drive. Flop output, glitch-free.
- `busy`  out  1  High from the first SOC tick through the last EOC tick.
- `tx_done`  out  1  One-tick pulse after the EOC completes.

## Operation
- **State machine: IDLE, SOC, DATA, EOC.** There is a 7-bit tick counter `cnt` (0..127); it is held at 0 in IDLE.
- **IDLE:**
  - `in_data_valid` sampled 1 → SOC with `cnt`=0.
  - `in_data` is not consumed.
- **SOC:** sequence D.
- **DATA:** sequence D if the captured bit is 1, sequence E if it is 0.
- **End of SOC/DATA (`cnt`==127):**
  - If `in_data_valid`==1: capture `in_data` into the bit register, pulse `in_req`, go to DATA.
  - Otherwise go to EOC.
- **EOC:** sequence F for 128 ticks. At `cnt`==127, go to IDLE and pulse `tx_done`.
- **Sequence shapes:**
  - D: modulated for `cnt` 0..63, unmodulated 64..127.
  - E: unmodulated 0..63, modulated 64..127.
  - F: unmodulated throughout.
- **Modulated means:** `lm_out` = NOT `cnt[3]`, i.e. 8 ticks high then 8 ticks low, 4 subcarrier periods per half-bit. Unmodulated means `lm_out`=0.
- **Input timing:** `in_data` and `in_data_valid` are ignored except at the IDLE sample and at `cnt`==127 of SOC/DATA. Changes mid-bit have no effect.
- **Empty frame:** `in_data_valid` low at the end of SOC gives SOC + EOC (D, F) with no `in_req`.
- **Frame length:** no limit. A frame ends only when `in_data_valid` is low at a bit boundary.
- **Reset:** asserting `rst_n` mid-frame forces all outputs to 0 asynchronously and returns the block to IDLE. No EOC is sent.

## Timing
- **Reset values:** `lm_out`=0, `in_req`=0, `busy`=0, `tx_done`=0, state IDLE, `cnt`=0, bit register 0.
- **Start:** let T be the edge at which `in_data_valid` is sampled 1 in IDLE.
  - Cycles T+1..T+128 are SOC.
  - `lm_out`=1 in cycles T+1..T+8 (1-tick latency).
- **Bit k (0-based):**
  - Captured at edge T+128(k+1).
  - `in_req` is high in cycle T+128(k+1)+1, which is `cnt`=0 of bit k.
  - The source updates `in_data`/`in_data_valid` at the edge where it sees `in_req`. The value is then stable by `cnt`=1, well before the next sample at `cnt`=127.
- **Frame of n bits:**
  - EOC occupies cycles T+128(n+1)+1..T+128(n+2).
  - `tx_done` is high in cycle T+128(n+2)+1, with `busy`=0 in that cycle.
- **Back-to-back frames:** IDLE lasts at least 1 cycle. `in_data_valid` high in the `tx_done` cycle starts the next SOC one cycle later.
- `busy`, `in_req` and `tx_done` are registered.

## Test plan
- **Single byte 0xA5, LSB first:**
  - Sequences D,D,E,D,E,E,D,E,D,F.
  - 8 `in_req` pulses at 128-tick spacing.
  - `busy` high for exactly 1280 cycles.
  - `tx_done` once, at T+1281.
- **Subcarrier shape:** capture `lm_out` over one D bit and one E bit.
  - D: 4×(8 high, 8 low), then 64 low.
  - E: 64 low, then 4×(8 high, 8 low).
  - No single-tick glitches.
- **Empty frame:** `in_data_valid` high for 1 cycle only.
  - D then F, 256 busy cycles, zero `in_req`, `tx_done` at T+257.
- **Mid-bit input changes:** toggle `in_data`/`in_data_valid` randomly at `cnt`≠127 with a fixed pattern at `cnt`==127.
  - Output matches that pattern exactly.
- **Back-to-back:** hold `in_data_valid` high through `tx_done` with 2 one-bit frames.
  - The second SOC starts in the cycle after the `tx_done` cycle.
  - No lost or duplicated bits.
- **Reset mid-frame:** assert `rst_n` low during a modulated tick of bit 3.
  - `lm_out`, `busy` and `in_req` go 0 immediately.
  - After release the block is IDLE and restarts correctly on the next `in_data_valid`.
